// File: rtl/wb_reg_file.sv
// Writeback-side register file: 8x16 registers, two registered read ports and a
// per-register pending-write scoreboard that drives the decode stall. Optional
// write-through bypass is enabled with `define REGFILE_BYPASS_EN.
module wb_reg_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int PEND_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  regWriteOut,
   input  logic [ADDR_WIDTH-1:0] loadAddr,
   input  logic [DATA_WIDTH-1:0] loadData,
   input  logic                  readEn,
   input  logic [ADDR_WIDTH-1:0] rs1Addr,
   input  logic [ADDR_WIDTH-1:0] rs2Addr,
   output logic [DATA_WIDTH-1:0] rs1Data,
   output logic [DATA_WIDTH-1:0] rs2Data,
   input  logic                  issueValid,
   input  logic                  issueRegWrite,
   input  logic [ADDR_WIDTH-1:0] issueRd,
   output logic                  busyRs1,
   output logic                  busyRs2,
   output logic                  hazard,
   output logic                  pendOverflow
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] CNT_MAX = {PEND_WIDTH{1'b1}};

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [PEND_WIDTH-1:0] cnt_q  [NUM_REGS];
   logic [PEND_WIDTH-1:0] cnt_d  [NUM_REGS];
   logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
   logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
   logic                  pend_overflow_q, pend_overflow_d;
   logic                  issue_wr;

   assign issue_wr = issueValid & issueRegWrite;

   always_comb begin
      regs_d = regs_q;
      if (regWriteOut) begin
         regs_d[loadAddr] = loadData;
      end
   end

   // Read ports sample the pre-write array unless bypass forwards the writeback.
   always_comb begin
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      if (readEn) begin
         rs1_data_d = regs_q[rs1Addr];
         rs2_data_d = regs_q[rs2Addr];
`ifdef REGFILE_BYPASS_EN
         if (regWriteOut && (loadAddr == rs1Addr)) begin
            rs1_data_d = loadData;
         end
         if (regWriteOut && (loadAddr == rs2Addr)) begin
            rs2_data_d = loadData;
         end
`endif
      end
   end

   // Saturating up/down counters; a stray writeback at zero leaves the count alone.
   always_comb begin
      cnt_d           = cnt_q;
      pend_overflow_d = pend_overflow_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         logic inc, dec;
         inc = issue_wr && (issueRd == ADDR_WIDTH'(r));
         dec = regWriteOut && (loadAddr == ADDR_WIDTH'(r));
         if (inc && !dec) begin
            if (cnt_q[r] == CNT_MAX) begin
               pend_overflow_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] + 1'b1;
            end
         end else if (dec && !inc) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         rs1_data_q      <= '0;
         rs2_data_q      <= '0;
         pend_overflow_q <= 1'b0;
      end else begin
         regs_q          <= regs_d;
         cnt_q           <= cnt_d;
         rs1_data_q      <= rs1_data_d;
         rs2_data_q      <= rs2_data_d;
         pend_overflow_q <= pend_overflow_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // The last outstanding write landing this cycle no longer blocks the reader.
   always_comb begin
      busyRs1 = (cnt_q[rs1Addr] != '0) &&
                !((cnt_q[rs1Addr] == PEND_WIDTH'(1)) && regWriteOut && (loadAddr == rs1Addr));
      busyRs2 = (cnt_q[rs2Addr] != '0) &&
                !((cnt_q[rs2Addr] == PEND_WIDTH'(1)) && regWriteOut && (loadAddr == rs2Addr));
   end
`else
   always_comb begin
      busyRs1 = (cnt_q[rs1Addr] != '0);
      busyRs2 = (cnt_q[rs2Addr] != '0);
   end
`endif

   assign hazard       = busyRs1 | busyRs2;
   assign rs1Data      = rs1_data_q;
   assign rs2Data      = rs2_data_q;
   assign pendOverflow = pend_overflow_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: read results checked through an expected
// queue, scoreboard/busy behaviour checked with immediate assertions.
module tb_wb_reg_file;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWriteOut;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] loadData;
  logic          readEn;
  logic [AW-1:0] rs1Addr, rs2Addr;
  logic [DW-1:0] rs1Data, rs2Data;
  logic          issueValid, issueRegWrite;
  logic [AW-1:0] issueRd;
  logic          busyRs1, busyRs2, hazard, pendOverflow;

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   ref_regs [8];

  wb_reg_file dut (
    .clk(clk), .reset(reset),
    .regWriteOut(regWriteOut), .loadAddr(loadAddr), .loadData(loadData),
    .readEn(readEn), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .issueValid(issueValid), .issueRegWrite(issueRegWrite), .issueRd(issueRd),
    .busyRs1(busyRs1), .busyRs2(busyRs2), .hazard(hazard),
    .pendOverflow(pendOverflow)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    regWriteOut = 1'b0; readEn = 1'b0; issueValid = 1'b0; issueRegWrite = 1'b0;
  endtask

  // driver tasks: each drives for exactly one edge, then releases the strobe
  task automatic drv_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    regWriteOut = 1'b1; loadAddr = a; loadData = d;
    ref_regs[a] = d;
    step();
    regWriteOut = 1'b0;
  endtask

  task automatic drv_issue(input logic [AW-1:0] rd);
    issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = rd;
    step();
    issueValid = 1'b0; issueRegWrite = 1'b0;
  endtask

  task automatic drv_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    readEn = 1'b1; rs1Addr = a1; rs2Addr = a2;
    exp_q.push_back({ref_regs[a1], ref_regs[a2]});
    step();
    readEn = 1'b0;
  endtask

  task automatic sb_compare(input string tag);
    logic [2*DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: observed empty queue expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {rs1Data, rs2Data}, e);
    end
  endtask

  initial begin
    logic [2*DW-1:0] last;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;

    // 1. Reset held with write/read/issue activity on the inputs
    reset = 1'b0;
    regWriteOut = 1'b1; loadAddr = 3'd5; loadData = 16'hAAAA;
    readEn = 1'b1; rs1Addr = 3'd5; rs2Addr = 3'd5;
    issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 3'd5;
    repeat (3) step();
    check("rst_rs1", 32'(rs1Data), 32'h0);
    check("rst_rs2", 32'(rs2Data), 32'h0);
    check("rst_hazard", 32'(hazard), 32'h0);
    check("rst_ovf", 32'(pendOverflow), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rel_hazard", 32'(hazard), 32'h0);
    drv_read(3'd5, 3'd5);
    sb_compare("rst_reg5");

    // 2. Write/read and hold
    drv_write(3'd5, 16'hAAAA);
    drv_write(3'd2, 16'hBBBB);
    drv_read(3'd5, 3'd2);
    sb_compare("rd_5_2");
    last = {16'hAAAA, 16'hBBBB};
    rs1Addr = 3'd0; rs2Addr = 3'd7;
    step();
    check("rd_hold", {rs1Data, rs2Data}, last);
    drv_write(3'd0, 16'h0123);
    drv_write(3'd7, 16'hFEDC);
    drv_read(3'd7, 3'd0);
    sb_compare("rd_r0_r7");
    for (int i = 0; i < 4; i++) begin
      drv_write(3'($urandom_range(0, 7)), 16'($urandom_range(0, 16'hFFFF)));
      drv_read(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      sb_compare("rd_rand");
    end

    // 3. Scoreboard
    rs1Addr = 3'd3; rs2Addr = 3'd0;
    drv_issue(3'd3);
    check("sb_busy1", 32'(busyRs1), 32'h1);
    check("sb_busy2", 32'(busyRs2), 32'h0);
    check("sb_hazard", 32'(hazard), 32'h1);
    regWriteOut = 1'b1; loadAddr = 3'd3; loadData = 16'h3333;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("sb_wb_cycle_busy", 32'(busyRs1), 32'h0);
`else
    check("sb_wb_cycle_busy", 32'(busyRs1), 32'h1);
`endif
    ref_regs[3] = 16'h3333;
    step();
    regWriteOut = 1'b0;
    check("sb_clear", 32'(busyRs1), 32'h0);
    check("sb_clear_hz", 32'(hazard), 32'h0);
    // same-edge issue and writeback at count 1: stays 1
    drv_issue(3'd3);
    issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 3'd3;
    regWriteOut = 1'b1; loadAddr = 3'd3; loadData = 16'h3434; ref_regs[3] = 16'h3434;
    step();
    idle();
    check("sb_same_edge1", 32'(busyRs1), 32'h1);
    drv_write(3'd3, 16'h3535);
    check("sb_drain", 32'(busyRs1), 32'h0);
    // same-edge at count 0: stays 0
    issueValid = 1'b1; issueRegWrite = 1'b1; issueRd = 3'd3;
    regWriteOut = 1'b1; loadAddr = 3'd3; loadData = 16'h3636; ref_regs[3] = 16'h3636;
    step();
    idle();
    check("sb_same_edge0", 32'(busyRs1), 32'h0);
    // issue without register write does not mark busy
    issueValid = 1'b1; issueRegWrite = 1'b0; issueRd = 3'd3;
    step();
    idle();
    check("sb_noregwrite", 32'(busyRs1), 32'h0);

    // 4. Saturation
    rs1Addr = 3'd1; rs2Addr = 3'd1;
    repeat (3) drv_issue(3'd1);
    check("sat_no_ovf", 32'(pendOverflow), 32'h0);
    drv_issue(3'd1);
    check("sat_ovf", 32'(pendOverflow), 32'h1);
    check("sat_busy", 32'(busyRs2), 32'h1);
    drv_write(3'd1, 16'h1001);
    check("sat_wb1_busy", 32'(busyRs1), 32'h1);
    drv_write(3'd1, 16'h1002);
    check("sat_wb2_busy", 32'(busyRs1), 32'h1);
    drv_write(3'd1, 16'h1003);
    check("sat_wb3_busy", 32'(busyRs1), 32'h0);
    step();
    check("sat_ovf_sticky", 32'(pendOverflow), 32'h1);

    // 5. Same-edge write and read
    drv_write(3'd4, 16'h1111);
    regWriteOut = 1'b1; loadAddr = 3'd4; loadData = 16'h2222;
    readEn = 1'b1; rs1Addr = 3'd4; rs2Addr = 3'd2;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back({16'h2222, ref_regs[2]});
`else
    exp_q.push_back({16'h1111, ref_regs[2]});
`endif
    ref_regs[4] = 16'h2222;
    step();
    idle();
    sb_compare("bypass_rd");
    drv_read(3'd4, 3'd4);
    sb_compare("after_bypass");

    // 6. Async reset mid-flight
    rs1Addr = 3'd6; rs2Addr = 3'd4;
    drv_issue(3'd6);
    check("mid_busy", 32'(busyRs1), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_data", {rs1Data, rs2Data}, 32'h0);
    check("mid_rst_hazard", 32'(hazard), 32'h0);
    check("mid_rst_ovf", 32'(pendOverflow), 32'h0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    step();
    check("rel_busy", 32'(busyRs1), 32'h0);
    drv_write(3'd6, 16'h6666);
    check("stray_busy", 32'(busyRs1), 32'h0);
    drv_issue(3'd6);
    check("post_issue_busy", 32'(busyRs1), 32'h1);
    drv_write(3'd6, 16'h6767);
    check("post_wb_busy", 32'(busyRs1), 32'h0);
    drv_read(3'd6, 3'd4);
    sb_compare("post_rst_rd");

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
